// File: rtl/pkt_commit_fifo_pkg.sv
// Shared sizing and pointer helpers for the
// packet commit FIFO and its RAM.
package pkt_commit_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic logic [31:0] ptr_diff(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          pw
  );
    logic [31:0] m;
    m = (32'd1 << pw) - 32'd1;
    return (a - b) & m;
  endfunction

endpackage

// File: rtl/pkt_commit_fifo_ram.sv
// Simple dual-port RAM, registered read data
// updated only when enableout is high.
module pkt_commit_fifo_ram
  import pkt_commit_fifo_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 11
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] rd_addr,
  input  logic               enableout,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [depth_of(A_WIDTH)];

  // Store a word on the write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Register the read word when a fetch is issued.
  always_ff @(posedge clk) begin
    if (enableout) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pkt_commit_fifo.sv
// Packet-aware FIFO: speculative frame writes with
// commit/rollback, FWFT read through a 2-entry skid.
module pkt_commit_fifo
  import pkt_commit_fifo_pkg::*;
#(
  parameter int D_WIDTH      = 8,
  parameter int A_WIDTH      = 11,
  parameter int AFULL_MARGIN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               wr_commit,
  input  logic               wr_discard,
  output logic               full,
  output logic               afull,
  output logic               pkt_dropped,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [D_WIDTH-1:0] rd_data,
  output logic [A_WIDTH:0]   level
);

  localparam int PW    = ptr_w(A_WIDTH);
  localparam int DEPTH = depth_of(A_WIDTH);
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] MARGIN_P =
    PW'(AFULL_MARGIN);

  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, pf_ptr;
  logic [PW-1:0] wr_nxt, used, avail;
  logic          ovf, ovf_now, wr_ok, drop_q;
  logic          ram_vld, issue, pop;
  logic [1:0]    cnt;
  logic [2:0]    outst;
  logic [D_WIDTH-1:0] s0, s1, ram_q;

  assign used  = PW'(ptr_diff(32'(wr_ptr),
                              32'(rd_ptr), PW));
  assign level = PW'(ptr_diff(32'(cmt_ptr),
                              32'(rd_ptr), PW));
  assign avail = PW'(ptr_diff(32'(cmt_ptr),
                              32'(pf_ptr), PW));

  assign full  = (used == DEPTH_P);
  assign afull = ((DEPTH_P - used) <= MARGIN_P);

  assign pkt_dropped = drop_q;
  assign rd_valid    = (cnt != 2'd0);
  assign rd_data     = s0;

  assign wr_ok   = wr_en & ~full;
  assign ovf_now = ovf | (wr_en & full);
  assign wr_nxt  = wr_ptr + {{(PW-1){1'b0}}, wr_ok};

  assign pop   = rd_valid & rd_ready;
  assign outst = {1'b0, cnt} + {2'b0, ram_vld};
  assign issue = (avail != '0) &&
                 (outst < (3'd2 + {2'b0, pop}));

  // Frame write pointer, commit and overflow drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      ovf     <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (wr_discard) begin
        wr_ptr <= cmt_ptr;
        ovf    <= 1'b0;
      end else if (wr_commit) begin
        ovf <= 1'b0;
        if (ovf_now) begin
          wr_ptr <= cmt_ptr;
          drop_q <= 1'b1;
        end else begin
          wr_ptr  <= wr_nxt;
          cmt_ptr <= wr_nxt;
        end
      end else begin
        wr_ptr <= wr_nxt;
        ovf    <= ovf_now;
      end
    end
  end

  // Prefetch committed words into the output skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      pf_ptr  <= '0;
      ram_vld <= 1'b0;
      cnt     <= 2'd0;
      s0      <= '0;
      s1      <= '0;
    end else begin
      ram_vld <= issue;
      if (issue) pf_ptr <= pf_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({pop, ram_vld})
        2'b11: begin
          if (cnt == 2'd2) begin
            s0 <= s1;
            s1 <= ram_q;
          end else begin
            s0 <= ram_q;
          end
        end
        2'b10: begin
          s0  <= s1;
          cnt <= cnt - 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd0) s0 <= ram_q;
          else             s1 <= ram_q;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  pkt_commit_fifo_ram #(
    .D_WIDTH(D_WIDTH),
    .A_WIDTH(A_WIDTH)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_ok & ~wr_discard),
    .wr_addr  (wr_ptr[A_WIDTH-1:0]),
    .wr_data  (wr_data),
    .rd_addr  (pf_ptr[A_WIDTH-1:0]),
    .enableout(issue),
    .rd_data  (ram_q)
  );

endmodule
